// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller.
// Holds the host/DDS register address map (only the low address byte is
// decoded), the ctrl register bit positions and the sweep FSM states.
package dds_pkg;

    // DDS register bus addresses; host writes here are forwarded.
    localparam logic [7:0] ADDR_AMP     = 8'h00;
    localparam logic [7:0] ADDR_FREQ    = 8'h04;
    localparam logic [7:0] ADDR_RES     = 8'h08;
    localparam logic [7:0] ADDR_PHASE   = 8'h0C;

    // Local sweep configuration registers.
    localparam logic [7:0] ADDR_F_START = 8'h10;
    localparam logic [7:0] ADDR_F_STOP  = 8'h14;
    localparam logic [7:0] ADDR_F_STEP  = 8'h18;
    localparam logic [7:0] ADDR_DWELL   = 8'h1C;
    localparam logic [7:0] ADDR_CTRL    = 8'h20;

    // ctrl register bits; all of them act only on the write that carries them.
    localparam int CTRL_START = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_ABORT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } sweep_state_t;

    function automatic logic is_dds_addr(input logic [7:0] a);
        return (a == ADDR_AMP) || (a == ADDR_FREQ) || (a == ADDR_RES) || (a == ADDR_PHASE);
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: 32-bit down counter.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (counter cleared)
//   load     in   load load_val into the counter this cycle
//   load_val in   cycles to count (caller guarantees >= 1)
//   expire   out  high during the last counted cycle
// With load in cycle t and load_val = N, expire is high in cycle t+N, so the
// N cycles t+1 .. t+N are counted.
module dds_dwell_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expire
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expire = (count == 32'd1);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: forwards host writes to the DDS register bus and runs
// a linear frequency sweep (f_start .. f_stop in f_step increments, holding
// each frequency for a programmable dwell) on the DDS frequency register.
// Ports:
//   sys_clk, sys_rst       clock; synchronous active-high reset
//   host_vld/addr/data     host register write; host_rdy accepts it
//   dds_vld/addr/data      registered DDS write strobe, one cycle per write
//   busy                   sweep running
//   done                   one-cycle pulse at sweep end or start rejection
//   err                    sticky, set by a rejected start
//   fsm_state              current sweep state, for observation
module dds_sweep_ctrl
    import dds_pkg::*;
(
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         host_vld,
    input  logic [31:0]  host_addr,
    input  logic [31:0]  host_data,
    output logic         host_rdy,
    output logic         dds_vld,
    output logic [31:0]  dds_addr,
    output logic [31:0]  dds_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output sweep_state_t fsm_state
);

    // Handshake: a host write transfers on every cycle where host_vld and
    // host_rdy are both high; the host holds addr/data until it transfers.
    // The sweep owns the DDS bus in its WR cycle, the only cycle host_rdy
    // is low, so a host write stalls at most one cycle per sweep step.

    sweep_state_t state, state_nxt;
    logic [31:0]  f_start, f_stop, f_step, dwell;
    logic [31:0]  sh_start, sh_stop, sh_step, sh_dwell;
    logic         sh_loop;
    logic [31:0]  cur, cur_nxt;
    logic         rej_q;
    logic [7:0]   a8;
    logic         wr_acc, ctrl_wr, start_req, abort_req;
    logic         can_start, start_bad, start_acc, start_rej;
    logic [32:0]  sum;
    logic         timer_load, timer_expire;
    logic         unused_addr_hi;

    assign a8             = host_addr[7:0];
    assign unused_addr_hi = ^host_addr[31:8];

    assign host_rdy  = (state != ST_WR);
    assign wr_acc    = host_vld & host_rdy;
    assign ctrl_wr   = wr_acc & (a8 == ADDR_CTRL);
    assign abort_req = ctrl_wr & host_data[CTRL_ABORT];
    // Abort wins over a start carried by the same write.
    assign start_req = ctrl_wr & host_data[CTRL_START] & ~host_data[CTRL_ABORT];
    // A non-looping sweep is no longer busy in its DONE cycle, so it may restart.
    assign can_start = (state == ST_IDLE) | ((state == ST_DONE) & ~sh_loop);
    assign start_bad = (f_step == 32'd0) | (f_start > f_stop);
    assign start_acc = start_req & can_start & ~start_bad;
    assign start_rej = start_req & can_start & start_bad;

    // 33-bit add so a wrap past 2^32 is seen as a carry and clamps to f_stop.
    assign sum = {1'b0, cur} + {1'b0, sh_step};

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nxt = ST_WR;
                    cur_nxt   = f_start;
                end
            end
            ST_WR: begin
                state_nxt  = ST_DWELL;
                timer_load = 1'b1;
            end
            ST_DWELL: begin
                if (timer_expire) state_nxt = ST_STEP;
            end
            ST_STEP: begin
                if (cur == sh_stop) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WR;
                    if (sum[32] || (sum[31:0] >= sh_stop)) cur_nxt = sh_stop;
                    else                                    cur_nxt = sum[31:0];
                end
            end
            ST_DONE: begin
                if (start_acc) begin
                    state_nxt = ST_WR;
                    cur_nxt   = f_start;
                end else if (sh_loop) begin
                    state_nxt = ST_WR;
                    cur_nxt   = sh_start;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_req) state_nxt = ST_IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            cur      <= 32'd0;
            f_start  <= 32'd0;
            f_stop   <= 32'd0;
            f_step   <= 32'd0;
            dwell    <= 32'd1;
            sh_start <= 32'd0;
            sh_stop  <= 32'd0;
            sh_step  <= 32'd0;
            sh_dwell <= 32'd1;
            sh_loop  <= 1'b0;
            err      <= 1'b0;
            rej_q    <= 1'b0;
            dds_vld  <= 1'b0;
            dds_addr <= 32'd0;
            dds_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;

            if (wr_acc) begin
                case (a8)
                    ADDR_F_START: f_start <= host_data;
                    ADDR_F_STOP:  f_stop  <= host_data;
                    ADDR_F_STEP:  f_step  <= host_data;
                    ADDR_DWELL:   dwell   <= host_data;
                    default: ;
                endcase
            end

            if (start_acc) begin
                sh_start <= f_start;
                sh_stop  <= f_stop;
                sh_step  <= f_step;
                sh_dwell <= dwell;
                sh_loop  <= host_data[CTRL_LOOP];
                err      <= 1'b0;
            end else if (start_rej) begin
                err <= 1'b1;
            end
            rej_q <= start_rej;

            dds_vld <= 1'b0;
            if (state == ST_WR) begin
                dds_vld  <= 1'b1;
                dds_addr <= {24'h0, ADDR_FREQ};
                dds_data <= cur;
            end else if (wr_acc && is_dds_addr(a8)) begin
                dds_vld  <= 1'b1;
                dds_addr <= {24'h0, a8};
                dds_data <= host_data;
            end
        end
    end

    dds_dwell_timer u_dwell_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .load     (timer_load),
        .load_val ((sh_dwell == 32'd0) ? 32'd1 : sh_dwell),
        .expire   (timer_expire)
    );

    assign busy      = (state == ST_WR) | (state == ST_DWELL) | (state == ST_STEP) |
                       ((state == ST_DONE) & sh_loop);
    assign done      = (state == ST_DONE) | rej_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and randomized sweeps checked against a
// frequency-list / timing model computed from the sweep rules.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    // ---------------- clock / reset ----------------
    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         host_vld = 1'b0;
    logic [31:0]  host_addr = 32'd0;
    logic [31:0]  host_data = 32'd0;
    logic         host_rdy, dds_vld, busy, done, err;
    logic [31:0]  dds_addr, dds_data;
    sweep_state_t fsm_state;

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    dds_sweep_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .host_vld  (host_vld),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_rdy  (host_rdy),
        .dds_vld   (dds_vld),
        .dds_addr  (dds_addr),
        .dds_data  (dds_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // ---------------- observation logs ----------------
    int          wr_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cyc_q[$];
    logic        done_busy_q[$];

    always @(negedge sys_clk) begin
        if (dds_vld) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(dds_addr);
            wr_data_q.push_back(dds_data);
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
    end

    task automatic clear_logs();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc_q.delete();
        done_busy_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frequencies a sweep writes: start, then start+k*step until reaching or
    // passing stop, where stop itself is written instead.
    function automatic void build_exp(input logic [31:0] fs, input logic [31:0] fe,
                                      input logic [31:0] st);
        longint c, n;
        exp_q.delete();
        c = longint'(fs);
        exp_q.push_back(fs);
        while (c != longint'(fe)) begin
            n = c + longint'(st);
            c = (n >= longint'(fe)) ? longint'(fe) : n;
            exp_q.push_back(32'(c));
        end
    endfunction

    // ---------------- drivers ----------------
    // acc = cycle number right after the accepting edge; stall = cycles with host_rdy low.
    task automatic host_write(input logic [7:0] a, input logic [31:0] d,
                              output int acc, output int stall);
        int tries;
        tries = 0;
        @(negedge sys_clk);
        host_vld  = 1'b1;
        host_addr = {24'($urandom), a};
        host_data = d;
        #1;
        while (!host_rdy && tries < 8) begin
            @(negedge sys_clk);
            #1;
            tries++;
        end
        stall = tries;
        acc   = cyc + 1;
        @(posedge sys_clk);
        #1;
        host_vld = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget && wr_cyc_q.size() < n; i++) @(negedge sys_clk);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_cyc_q.size() < n; i++) @(negedge sys_clk);
    endtask

    // Program and run one non-looping sweep, then compare every DDS write,
    // its cycle, and the done pulse with the model.
    task automatic sweep_check(input string tag, input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input logic [31:0] dw,
                               input bit after_reset);
        int s, stall, n, dwc, ecyc;
        if (!after_reset) begin
            host_write(ADDR_F_START, fs, s, stall);
            host_write(ADDR_DWELL, dw, s, stall);
        end
        host_write(ADDR_F_STOP, fe, s, stall);
        host_write(ADDR_F_STEP, st, s, stall);
        dwc = after_reset ? 1 : ((dw == 32'd0) ? 1 : int'(dw));
        build_exp(fs, fe, st);
        n = exp_q.size();
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        wait_done(1, n * (dwc + 2) + 20);
        repeat (4) @(negedge sys_clk);
        check({tag, "_nwr"}, wr_cyc_q.size(), n);
        for (int i = 0; i < n && i < wr_cyc_q.size(); i++) begin
            ecyc = s + 1 + i * (dwc + 2);
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_q[i]);
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'h04);
            check($sformatf("%s_cyc%0d", tag, i), wr_cyc_q[i], ecyc);
        end
        check({tag, "_ndone"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) begin
            check({tag, "_done_cyc"}, done_cyc_q[0], s + 1 + (n - 1) * (dwc + 2) + dwc + 1);
            check({tag, "_busy_at_done"}, done_busy_q[0], 1'b0);
        end
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_err_end"}, err, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s, stall, x, k, nd, per, d0;
        logic [31:0] a1, d1, a2, d2;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst_host_rdy", host_rdy, 1'b1);
        check("rst_dds_vld", dds_vld, 1'b0);
        check("rst_dds_addr", dds_addr, 32'd0);
        check("rst_dds_data", dds_data, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        sys_rst = 1'b0;

        // Forwarding with one-cycle latency; unmapped addresses discarded
        clear_logs();
        host_write(ADDR_AMP, 32'd128, s, stall);
        check("fwd_stall", stall, 0);
        repeat (2) @(negedge sys_clk);
        check("fwd_nwr", wr_cyc_q.size(), 1);
        if (wr_cyc_q.size() > 0) begin
            check("fwd_cyc", wr_cyc_q[0], s);
            check("fwd_addr", wr_addr_q[0], 32'h00);
            check("fwd_data", wr_data_q[0], 32'd128);
        end
        clear_logs();
        d1 = $urandom;
        host_write(ADDR_RES, d1, s, stall);
        host_write(8'h24, $urandom, x, stall);
        host_write(8'h05, $urandom, x, stall);
        repeat (3) @(negedge sys_clk);
        check("fwd2_nwr", wr_cyc_q.size(), 1);
        if (wr_cyc_q.size() > 0) begin
            check("fwd2_addr", wr_addr_q[0], 32'h08);
            check("fwd2_data", wr_data_q[0], d1);
        end

        // Directed sweeps: nominal, clamp on carry, single-point
        sweep_check("sweep", 32'd1000, 32'd1300, 32'd100, 32'd4, 1'b0);
        sweep_check("clamp", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 32'd0, 1'b0);
        sweep_check("equal", 32'd777, 32'd777, 32'd5, 32'd2, 1'b0);

        // Randomized sweeps
        for (int r = 0; r < 5; r++) begin
            logic [31:0] fs, fe, st, dw;
            st = $urandom_range(1, 5000);
            fs = $urandom_range(0, 32'h7FFF_FFFF);
            fe = fs + st * $urandom_range(0, 5) + $urandom_range(0, st - 1);
            dw = $urandom_range(0, 5);
            sweep_check($sformatf("rand%0d", r), fs, fe, st, dw, 1'b0);
        end

        // Collision: host write lands on the sweep's WR cycle
        host_write(ADDR_F_START, 32'd1000, s, stall);
        host_write(ADDR_F_STOP, 32'd1300, s, stall);
        host_write(ADDR_F_STEP, 32'd100, s, stall);
        host_write(ADDR_DWELL, 32'd4, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        wait_wr(1, 40);
        x = -100;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (fsm_state == ST_WR) begin
                x = cyc;
                break;
            end
        end
        host_vld  = 1'b1;
        host_addr = {24'($urandom), ADDR_PHASE};
        host_data = 32'd512;
        #1;
        check("coll_rdy_low", host_rdy, 1'b0);
        @(negedge sys_clk);
        #1;
        check("coll_rdy_high", host_rdy, 1'b1);
        @(posedge sys_clk);
        #1;
        host_vld = 1'b0;
        wait_done(1, 60);
        repeat (3) @(negedge sys_clk);
        a1 = 32'hDEAD; d1 = 32'hDEAD; a2 = 32'hDEAD; d2 = 32'hDEAD;
        foreach (wr_cyc_q[i]) begin
            if (wr_cyc_q[i] == x + 1) begin a1 = wr_addr_q[i]; d1 = wr_data_q[i]; end
            if (wr_cyc_q[i] == x + 2) begin a2 = wr_addr_q[i]; d2 = wr_data_q[i]; end
        end
        check("coll_sweep_addr", a1, 32'h04);
        check("coll_sweep_data", d1, 32'd1100);
        check("coll_host_addr", a2, 32'h0C);
        check("coll_host_data", d2, 32'd512);
        check("coll_nwr", wr_cyc_q.size(), 5);
        check("coll_ndone", done_cyc_q.size(), 1);

        // Rejections: zero step, then start above stop; abort+start does nothing
        host_write(ADDR_F_START, 32'd100, s, stall);
        host_write(ADDR_F_STOP, 32'd200, s, stall);
        host_write(ADDR_F_STEP, 32'd0, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        check("rej0_err", err, 1'b1);
        repeat (4) @(negedge sys_clk);
        check("rej0_nwr", wr_cyc_q.size(), 0);
        check("rej0_ndone", done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) check("rej0_done_cyc", done_cyc_q[0], s);
        check("rej0_busy", busy, 1'b0);
        host_write(ADDR_F_STEP, 32'd10, s, stall);
        host_write(ADDR_F_START, 32'd300, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        repeat (4) @(negedge sys_clk);
        check("rej1_err", err, 1'b1);
        check("rej1_nwr", wr_cyc_q.size(), 0);
        check("rej1_ndone", done_cyc_q.size(), 1);
        host_write(ADDR_F_START, 32'd100, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h5, s, stall);
        repeat (5) @(negedge sys_clk);
        check("abst_nwr", wr_cyc_q.size(), 0);
        check("abst_ndone", done_cyc_q.size(), 0);
        check("abst_busy", busy, 1'b0);
        check("abst_err", err, 1'b1);

        // Abort after the second write; start while busy is ignored
        host_write(ADDR_F_START, 32'd1000, s, stall);
        host_write(ADDR_F_STOP, 32'd1300, s, stall);
        host_write(ADDR_F_STEP, 32'd100, s, stall);
        host_write(ADDR_DWELL, 32'd4, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        check("abt_err_cleared", err, 1'b0);
        wait_wr(1, 20);
        host_write(ADDR_CTRL, 32'h1, s, stall);
        check("abt_busy_restart_err", err, 1'b0);
        wait_wr(2, 20);
        host_write(ADDR_CTRL, 32'h4, s, stall);
        check("abt_busy_after", busy, 1'b0);
        repeat (30) @(negedge sys_clk);
        check("abt_nwr", wr_cyc_q.size(), 2);
        check("abt_ndone", done_cyc_q.size(), 0);
        if (wr_cyc_q.size() > 1) check("abt_data1", wr_data_q[1], 32'd1100);

        // Loop mode: two passes, done once per pass with busy held
        host_write(ADDR_F_START, 32'd10, s, stall);
        host_write(ADDR_F_STOP, 32'd30, s, stall);
        host_write(ADDR_F_STEP, 32'd10, s, stall);
        host_write(ADDR_DWELL, 32'd2, s, stall);
        build_exp(32'd10, 32'd30, 32'd10);
        k = exp_q.size();
        per = (k - 1) * 4 + 2 + 3;
        clear_logs();
        host_write(ADDR_CTRL, 32'h3, s, stall);
        wait_done(2, 80);
        host_write(ADDR_CTRL, 32'h4, x, stall);
        check("loop_busy_abort", busy, 1'b0);
        repeat (10) @(negedge sys_clk);
        check("loop_nwr_ge", wr_cyc_q.size() >= 2 * k, 1'b1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < k; i++) begin
                nd = p * k + i;
                if (nd < wr_cyc_q.size()) begin
                    check($sformatf("loop_data%0d", nd), wr_data_q[nd], exp_q[i]);
                    check($sformatf("loop_cyc%0d", nd), wr_cyc_q[nd], s + 1 + p * per + i * 4);
                end
            end
        end
        check("loop_ndone_ge", done_cyc_q.size() >= 2, 1'b1);
        if (done_cyc_q.size() >= 2) begin
            d0 = s + 1 + (k - 1) * 4 + 3;
            check("loop_done0", done_cyc_q[0], d0);
            check("loop_done1", done_cyc_q[1], d0 + per);
            check("loop_busy_at_done", done_busy_q[0], 1'b1);
        end

        // Reset during DWELL, then restart from cleared registers
        host_write(ADDR_F_START, 32'd1000, s, stall);
        host_write(ADDR_F_STOP, 32'd1300, s, stall);
        host_write(ADDR_F_STEP, 32'd100, s, stall);
        host_write(ADDR_DWELL, 32'd8, s, stall);
        clear_logs();
        host_write(ADDR_CTRL, 32'h1, s, stall);
        wait_wr(1, 20);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mrst_host_rdy", host_rdy, 1'b1);
        check("mrst_dds_vld", dds_vld, 1'b0);
        check("mrst_dds_addr", dds_addr, 32'd0);
        check("mrst_dds_data", dds_data, 32'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_err", err, 1'b0);
        @(negedge sys_clk);
        check("mrst_nwr", wr_cyc_q.size(), 1);
        sweep_check("post_rst", 32'd0, 32'd200, 32'd100, 32'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
